// File: rtl/symbol_renderer.sv
// Renders one 5x5 cell of 2-bit pixel codes from a 50-bit symbol word as a valid/ready pixel stream.
// First pixel is offered two edges after start; pixels hold while pix_ready is low. Optional macro: SYMBOL_TRANSPARENT_EN.
module symbol_renderer #(
  parameter logic [11:0] PAL0 = 12'h000,
  parameter logic [11:0] PAL1 = 12'h0F0,
  parameter logic [11:0] PAL2 = 12'hF00,
  parameter logic [11:0] PAL3 = 12'hFFF
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  start_figure,
  input  logic [4:0]  start_col,
  input  logic [4:0]  start_row,
  output logic [3:0]  selected_figure,
  input  logic [49:0] selected_symbol,
  output logic        busy,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, STREAM, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_fig;
  logic [4:0]  r_col;
  logic [4:0]  r_row;
  logic [49:0] r_shift;
  logic [4:0]  r_idx;
  logic [2:0]  r_cx;
  logic [2:0]  r_cy;

  logic [1:0]  w_code;
  logic        w_capture;
  logic        w_load;
  logic        w_adv;
  logic        w_skip;

  assign w_code          = r_shift[49:48];
  assign selected_figure = r_fig;

  always_ff @(posedge clock_25) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    pix_valid = 1'b0;
    done      = 1'b0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_skip    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = WAIT;
        end
      end
      WAIT: w_next = LOAD;
      LOAD: begin
        w_load = 1'b1;
        w_next = STREAM;
      end
      STREAM: begin
`ifdef SYMBOL_TRANSPARENT_EN
        w_skip = (w_code == 2'b00);
`endif
        pix_valid = !w_skip;
        // a skipped pixel advances on its own, without waiting for the consumer
        w_adv = w_skip | pix_ready;
        if (w_adv && (r_idx == 5'd24)) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      r_fig   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else begin
      if (w_capture) begin
        r_fig <= start_figure;
        r_col <= start_col;
        r_row <= start_row;
      end
      if (w_load) begin
        r_shift <= selected_symbol;
        r_idx   <= '0;
        r_cx    <= '0;
        r_cy    <= '0;
      end else if (w_adv) begin
        r_shift <= {r_shift[47:0], 2'b00};
        r_idx   <= r_idx + 5'd1;
        // column/row offsets tracked directly instead of dividing the index by 5
        if (r_cx == 3'd4) begin
          r_cx <= '0;
          r_cy <= r_cy + 3'd1;
        end else begin
          r_cx <= r_cx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    pix_x   = '0;
    pix_y   = '0;
    pix_rgb = '0;
    if (r_state == STREAM) begin
      pix_x = {3'b000, r_col} * 8'd5 + {5'b00000, r_cx};
      pix_y = {3'b000, r_row} * 8'd5 + {5'b00000, r_cy};
      case (w_code)
        2'b00:   pix_rgb = PAL0;
        2'b01:   pix_rgb = PAL1;
        2'b10:   pix_rgb = PAL2;
        default: pix_rgb = PAL3;
      endcase
    end
  end

endmodule
